// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its neighbours.
package fetch_pkg;

  localparam int unsigned DefaultPcWidth    = 16;
  localparam int unsigned DefaultInstrWidth = 16;

  localparam logic [DefaultInstrWidth-1:0] NopInstr = '0;

  typedef enum logic [2:0] {
    StStart,
    StIssue,
    StWait,
    StHold,
    StDrop
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register; clear takes priority over load.
module fetch_skid_buffer #(
  parameter int unsigned PcWidth    = 16,
  parameter int unsigned InstrWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [PcWidth-1:0]    pc_i,
  input  logic [InstrWidth-1:0] instr_i,
  output logic                  full_o,
  output logic [PcWidth-1:0]    pc_o,
  output logic [InstrWidth-1:0] instr_o
);

  logic                  full_d, full_q;
  logic [PcWidth-1:0]    pc_d, pc_q;
  logic [InstrWidth-1:0] instr_d, instr_q;

  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests and
// presents fetched instructions to ifPipeReg, honouring stall and EX redirects.
module fetch_unit import fetch_pkg::*; #(
  parameter int unsigned PC_WIDTH    = DefaultPcWidth,
  parameter int unsigned INSTR_WIDTH = DefaultInstrWidth,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned PC_STEP     = 1
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  output logic                   imemReq,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic                   imemValid,
  input  logic [INSTR_WIDTH-1:0] imemData,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirectPc,
  output logic [PC_WIDTH-1:0]    pcOut,
  output logic [INSTR_WIDTH-1:0] instrOut,
  output logic                   validOut
);

  fetch_state_e           state_d, state_q;
  logic [PC_WIDTH-1:0]    pc_d, pc_q;
  logic [PC_WIDTH-1:0]    pc_out_d, pc_out_q;
  logic [INSTR_WIDTH-1:0] instr_out_d, instr_out_q;
  logic                   valid_d, valid_q;

  logic                   skid_load, skid_clear, skid_full;
  logic [PC_WIDTH-1:0]    skid_pc;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic                   slot_free, redirect_en;
  logic [PC_WIDTH-1:0]    pc_next;

  assign slot_free   = !valid_q || !stall;
  assign redirect_en = redirect && (state_q != StStart);
  assign pc_next     = pc_q + PC_WIDTH'(PC_STEP);

  fetch_skid_buffer #(
    .PcWidth    (PC_WIDTH),
    .InstrWidth (INSTR_WIDTH)
  ) u_skid (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .instr_i (imemData),
    .full_o  (skid_full),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    instr_out_d = instr_out_q;
    // A presented instruction is dropped once ifPipeReg takes it.
    valid_d     = valid_q && stall;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;

    unique case (state_q)
      StStart: state_d = StIssue;
      StIssue: state_d = redirect ? StDrop : StWait;
      StWait: begin
        if (redirect) begin
          state_d = imemValid ? StIssue : StDrop;
        end else if (imemValid) begin
          pc_d = pc_next;
          if (slot_free) begin
            pc_out_d    = pc_q;
            instr_out_d = imemData;
            valid_d     = 1'b1;
            state_d     = StIssue;
          end else begin
            skid_load = 1'b1;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          state_d = StIssue;
        end else if (slot_free) begin
          pc_out_d    = skid_pc;
          instr_out_d = skid_instr;
          valid_d     = 1'b1;
          skid_clear  = 1'b1;
          state_d     = StIssue;
        end
      end
      StDrop: begin
        if (imemValid) begin
          state_d = StIssue;
        end
      end
      default: state_d = StStart;
    endcase

    // Redirect flushes everything fetched so far, even while stalled.
    if (redirect_en) begin
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      skid_load  = 1'b0;
      pc_d       = redirectPc;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StStart;
      pc_q        <= PC_WIDTH'(RESET_PC);
      pc_out_q    <= '0;
      instr_out_q <= INSTR_WIDTH'(NopInstr);
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_out_q    <= pc_out_d;
      instr_out_q <= instr_out_d;
      valid_q     <= valid_d;
    end
  end

  assign imemReq  = (state_q == StIssue);
  assign imemAddr = pc_q;
  assign pcOut    = pc_out_q;
  assign instrOut = instr_out_q;
  assign validOut = valid_q;

endmodule
